// File: rtl/game_ctrl.sv
// Game control FSM: frame tick, lives, BCD score and enemy respawn.
// Define GAME_CTRL_INVULN_EN to add post-hit ship invulnerability.
module game_ctrl #(
    parameter int unsigned VIDAS_INICIAIS = 3,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned INVULN_FRAMES  = 90
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        VGA_VS,
    input  logic        start,
    input  logic        pausa,
    input  logic        hit_inimigo,
    input  logic        hit_nave,
    output logic [1:0]  estado,
    output logic        update_en,
    output logic        perdeu,
    output logic        inimigo_vivo,
    output logic [1:0]  vidas,
    output logic [15:0] pontos
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StJogando = 2'd1,
        StPausa   = 2'd2,
        StPerdeu  = 2'd3
    } state_e;

    state_e      r_state, w_state_d;
    logic        r_vs, r_armed, r_update_en, w_tick;
    logic        r_vivo, w_vivo_d;
    logic [1:0]  r_vidas, w_vidas_d;
    logic [15:0] r_pontos, w_pontos_d;
    logic [7:0]  r_respawn, w_respawn_d;
    logic        w_vulneravel;

`ifdef GAME_CTRL_INVULN_EN
    logic [7:0]  r_invuln, w_invuln_d;
    assign w_vulneravel = (r_invuln == 8'd0);
`else
    logic        w_unused_invuln;
    assign w_vulneravel    = 1'b1;
    assign w_unused_invuln = ^INVULN_FRAMES;
`endif

    function automatic logic [15:0] f_bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v == 16'h9999) begin
            return v;
        end
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // r_armed holds off a tick on the first edge after reset release.
    assign w_tick = r_armed & r_vs & ~VGA_VS;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_vs        <= 1'b1;
            r_armed     <= 1'b0;
            r_update_en <= 1'b0;
        end else begin
            r_vs        <= VGA_VS;
            r_armed     <= 1'b1;
            r_update_en <= w_tick && (r_state == StJogando);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_vivo    <= 1'b0;
            r_vidas   <= 2'd0;
            r_pontos  <= 16'h0000;
            r_respawn <= 8'd0;
`ifdef GAME_CTRL_INVULN_EN
            r_invuln  <= 8'd0;
`endif
        end else begin
            r_state   <= w_state_d;
            r_vivo    <= w_vivo_d;
            r_vidas   <= w_vidas_d;
            r_pontos  <= w_pontos_d;
            r_respawn <= w_respawn_d;
`ifdef GAME_CTRL_INVULN_EN
            r_invuln  <= w_invuln_d;
`endif
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_vivo_d    = r_vivo;
        w_vidas_d   = r_vidas;
        w_pontos_d  = r_pontos;
        w_respawn_d = r_respawn;
`ifdef GAME_CTRL_INVULN_EN
        w_invuln_d  = r_invuln;
`endif
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d   = StJogando;
                    w_vidas_d   = 2'(VIDAS_INICIAIS);
                    w_pontos_d  = 16'h0000;
                    w_vivo_d    = 1'b1;
                    w_respawn_d = 8'd0;
`ifdef GAME_CTRL_INVULN_EN
                    w_invuln_d  = 8'd0;
`endif
                end
            end
            StJogando: begin
                if (w_tick && !r_vivo) begin
                    if (r_respawn <= 8'd1) begin
                        w_respawn_d = 8'd0;
                        w_vivo_d    = 1'b1;
                    end else begin
                        w_respawn_d = r_respawn - 8'd1;
                    end
                end
`ifdef GAME_CTRL_INVULN_EN
                if (w_tick && (r_invuln != 8'd0)) begin
                    w_invuln_d = r_invuln - 8'd1;
                end
`endif
                if (pausa) begin
                    w_state_d = StPausa;
                end else begin
                    if (hit_inimigo && r_vivo) begin
                        w_vivo_d    = 1'b0;
                        w_respawn_d = 8'(RESPAWN_FRAMES);
                        w_pontos_d  = f_bcd_inc(r_pontos);
                    end
                    if (hit_nave && w_vulneravel) begin
`ifdef GAME_CTRL_INVULN_EN
                        w_invuln_d = 8'(INVULN_FRAMES);
`endif
                        if (r_vidas <= 2'd1) begin
                            w_vidas_d   = 2'd0;
                            w_state_d   = StPerdeu;
                            w_vivo_d    = 1'b0;
                            w_respawn_d = 8'd0;
                        end else begin
                            w_vidas_d = r_vidas - 2'd1;
                        end
                    end
                end
            end
            StPausa: begin
                if (!pausa) begin
                    w_state_d = StJogando;
                end
            end
            StPerdeu: begin
                if (start) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        estado       = r_state;
        perdeu       = (r_state == StPerdeu);
        update_en    = r_update_en;
        inimigo_vivo = r_vivo;
        vidas        = r_vidas;
        pontos       = r_pontos;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter VIDAS_INICIAIS, default 3, lives loaded at game start (legal 1..3).
REQ-002 Parameter RESPAWN_FRAMES, default 60, frames the enemy stays dead after a hit (legal 1..255).
REQ-003 Parameter INVULN_FRAMES, default 90, frames of ship invulnerability after a hit (legal 1..255).
REQ-004 CLOCK_50  in  1  sole clock; all state is updated on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 VGA_VS  in  1  VGA vertical sync, generated in the CLOCK_50 domain; active-low pulse.
REQ-007 start  in  1  one-cycle pulse from the debounced keys.
REQ-008 pausa  in  1  level; 1 requests pause.
REQ-009 hit_inimigo  in  1  one-cycle pulse; allied ball collided with the enemy.
REQ-010 hit_nave  in  1  one-cycle pulse; enemy ball collided with the ship.
REQ-011 estado  out  2  state: 0 IDLE, 1 JOGANDO, 2 PAUSA, 3 PERDEU.
REQ-012 update_en  out  1  one-cycle pulse per frame authorising entity movement.
REQ-013 perdeu  out  1  high only in state PERDEU.
REQ-014 inimigo_vivo  out  1  enemy is drawn and can be hit.
REQ-015 vidas  out  2  remaining lives.
REQ-016 pontos  out  16  score, 4 BCD digits, [3:0] least significant.

Function
REQ-017 Frame tick: VGA_VS is registered once; a tick occurs in the cycle where the registered value is 1 and VGA_VS is 0.
REQ-018 update_en is registered: high exactly one cycle, the cycle after a tick, only if estado=JOGANDO at the tick; otherwise 0.
REQ-019 IDLE: start -> JOGANDO next cycle; on that transition vidas=VIDAS_INICIAIS, pontos=0, inimigo_vivo=1, respawn and invulnerability counters cleared.
REQ-020 JOGANDO: pausa=1 -> PAUSA; pausa has priority and all hit pulses are ignored in any cycle where pausa=1.
REQ-021 PAUSA: pausa=0 -> JOGANDO; hits ignored; respawn and invulnerability counters frozen; ticks produce no update_en.
REQ-022 hit_inimigo in JOGANDO with inimigo_vivo=1: inimigo_vivo=0, respawn counter=RESPAWN_FRAMES, pontos incremented by 1 in BCD with per-digit carry; pontos saturates at 9999 (0x9999).
REQ-023 hit_inimigo with inimigo_vivo=0: ignored.
REQ-024 Respawn: each tick in JOGANDO with inimigo_vivo=0 decrements the counter; the tick that brings it to 0 sets inimigo_vivo=1 in the same update.
REQ-025 hit_nave in JOGANDO (and not invulnerable, see REQ-031): vidas decremented; if vidas was 1, vidas=0 and estado -> PERDEU next cycle.
REQ-026 hit_nave and hit_inimigo in the same cycle: both processed; score still increments even when the same cycle causes PERDEU.
REQ-027 PERDEU: perdeu=1, inimigo_vivo=0, no update_en; start -> IDLE; pontos and vidas hold until the next IDLE->JOGANDO transition.
REQ-028 start in JOGANDO or PAUSA: ignored.

Reset
REQ-029 While reset=0: estado=IDLE, update_en=0, perdeu=0, inimigo_vivo=0, vidas=0, pontos=0, all internal counters 0, VS register=1; this applies immediately and asynchronously, including mid-game.
REQ-030 After reset release, the first tick cannot occur before the second clock edge.

Configuration
REQ-031 Macro GAME_CTRL_INVULN_EN defined: a counted hit_nave loads the invulnerability counter with INVULN_FRAMES; the counter decrements on each tick in JOGANDO; hit_nave is ignored while the counter is nonzero.
REQ-032 Macro GAME_CTRL_INVULN_EN undefined: no invulnerability counter exists; every hit_nave in JOGANDO with pausa=0 is counted; INVULN_FRAMES is unused.

Verification
REQ-033 Reset; start pulse; 3 VS falling edges -> estado=1, vidas=3, pontos=0x0000, inimigo_vivo=1, exactly 3 update_en pulses, each 1 cycle after its tick.
REQ-034 JOGANDO with pontos=0x0009; hit_inimigo -> pontos=0x0010, inimigo_vivo=0; after 60 ticks inimigo_vivo=1 (still 0 after 59).
REQ-035 pausa=1 for 10 frames with hit_nave and hit_inimigo pulses -> estado=2, no update_en, vidas and pontos unchanged; pausa=0 -> estado=1.
REQ-036 Invuln undefined, vidas=1; hit_nave and hit_inimigo in the same cycle -> estado=3, perdeu=1, vidas=0, pontos+1; start -> estado=0.
REQ-037 Invuln defined; two hit_nave pulses 5 frames apart -> vidas 3->2 only; a third hit 91 frames after the first -> vidas=1.
REQ-038 pontos=0x9999 plus hit_inimigo -> pontos stays 0x9999; reset=0 asserted mid-frame -> all outputs zero before the next clock edge.
